fx3_xfer_scheduler: RTL and testbench

Arbitrates FX3 bulk-in transfers between multiple buffer sources (loopback and subsystem buffers) feeding the FX3 data loader. It grants one requester at a time and sequences the start/done handshake with the loader. It supervises each transfer with a timeout and reports per-requester completion pulses. It sits in the sys_clk domain between the buffer-ready flags and the loader's buffer-select input.

---
 rtl/fx3_xfer_scheduler.sv | 163 ++++++++++++++++
 tb/tb_fx3_xfer_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_xfer_scheduler.sv
// fx3_xfer_scheduler: arbitrates FX3 bulk-in transfers between buffer sources,
// sequences the start/done handshake with the data loader, supervises each
// transfer with a timeout and reports per-requester completion pulses.
module fx3_xfer_scheduler #(
  parameter int unsigned REQ_NUM   = 4,
  parameter int unsigned HI_PRIO0  = 0,
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned IDX_W     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst_n,
  input  logic                 i_frame_rst,
  input  logic                 i_enable,
  input  logic [REQ_NUM-1:0]   i_req,
  input  logic                 i_loader_ready,
  input  logic                 i_loader_done,
  output logic [REQ_NUM-1:0]   o_grant,
  output logic [IDX_W-1:0]     o_grant_idx,
  output logic                 o_xfer_start,
  output logic [REQ_NUM-1:0]   o_xfer_done,
  output logic                 o_busy,
  output logic                 o_timeout_err,
  output logic [31:0]          o_xfer_cnt
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_START = 4'b0010,
    S_XFER  = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  state_t                r_state;
  logic [REQ_NUM-1:0]    r_grant;
  logic [IDX_W-1:0]      r_grant_idx;
  logic                  r_xfer_start;
  logic [REQ_NUM-1:0]    r_xfer_done;
  logic                  r_busy;
  logic                  r_timeout_err;
  logic [CNT_W-1:0]      r_xfer_cnt;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [TIMEOUT_W-1:0]  r_timer;
  logic                  r_normal;

  logic                  w_win_found;
  logic [IDX_W-1:0]      w_win_idx;
  logic [REQ_NUM-1:0]    w_win_oh;
  logic [IDX_W-1:0]      w_rr_next;
  logic [31:0]           w_pos;

  // Winner selection: round-robin scan from rr_ptr, optionally overridden by requester 0
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_pos       = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      w_pos = 32'(r_rr_ptr) + 32'(k);
      if (w_pos >= 32'(REQ_NUM)) begin
        w_pos = w_pos - 32'(REQ_NUM);
      end
      if (!w_win_found && i_req[w_pos[IDX_W-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_pos[IDX_W-1:0];
      end
    end
    if ((HI_PRIO0 != 0) && i_req[0]) begin
      w_win_found = 1'b1;
      w_win_idx   = '0;
    end
  end

  // One-hot form of the winner and the round-robin pointer after the current grant
  always_comb begin
    w_win_oh  = REQ_NUM'(1) << w_win_idx;
    w_rr_next = (r_grant_idx == IDX_W'(REQ_NUM - 1)) ? '0 : r_grant_idx + IDX_W'(1);
  end

  // Scheduler FSM with registered outputs; frame_rst clears everything except grant_idx
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_xfer_start  <= 1'b0;
      r_xfer_done   <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_xfer_cnt    <= '0;
      r_rr_ptr      <= '0;
      r_timer       <= '0;
      r_normal      <= 1'b0;
    end else if (i_frame_rst) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_xfer_start  <= 1'b0;
      r_xfer_done   <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_xfer_cnt    <= '0;
      r_rr_ptr      <= '0;
      r_timer       <= '0;
      r_normal      <= 1'b0;
    end else begin
      r_xfer_start <= 1'b0;
      r_xfer_done  <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (i_enable && i_loader_ready && w_win_found) begin
            r_grant      <= w_win_oh;
            r_grant_idx  <= w_win_idx;
            r_xfer_start <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_START;
          end
        end
        S_START: begin
          r_timer <= '0;
          r_state <= S_XFER;
        end
        S_XFER: begin
          // loader_done beats a coinciding terminal count
          if (i_loader_done) begin
            r_normal    <= 1'b1;
            r_xfer_done <= r_grant;
            r_state     <= S_DONE;
          end else if (r_timer == '1) begin
            r_normal      <= 1'b0;
            r_timeout_err <= 1'b1;
            r_xfer_done   <= r_grant;
            r_state       <= S_DONE;
          end else begin
            r_timer <= r_timer + TIMEOUT_W'(1);
          end
        end
        S_DONE: begin
          if (r_normal) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
          end
          r_rr_ptr <= w_rr_next;
          r_grant  <= '0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_idx   = r_grant_idx;
  assign o_xfer_start  = r_xfer_start;
  assign o_xfer_done   = r_xfer_done;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_timeout_err;
  assign o_xfer_cnt    = r_xfer_cnt;

endmodule

// File: tb/tb_fx3_xfer_scheduler.sv
// Testbench for fx3_xfer_scheduler: table of single-cycle vectors plus
// hand-written sequences for arbitration, timeout, abort and reset.
module tb_fx3_xfer_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_rst = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic        loader_ready = 1'b0;
  logic        loader_done = 1'b0;

  logic [3:0]  a_grant, b_grant;
  logic [1:0]  a_idx, b_idx;
  logic        a_start, b_start;
  logic [3:0]  a_xd, b_xd;
  logic        a_busy, b_busy;
  logic        a_terr, b_terr;
  logic [31:0] a_cnt, b_cnt;

  int n_chk = 0;
  int n_pass = 0;

  // Round-robin instance
  fx3_xfer_scheduler #(.REQ_NUM(4), .HI_PRIO0(0), .TIMEOUT_W(4)) u_dut_a (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_frame_rst(frame_rst), .i_enable(enable),
    .i_req(req), .i_loader_ready(loader_ready), .i_loader_done(loader_done),
    .o_grant(a_grant), .o_grant_idx(a_idx), .o_xfer_start(a_start), .o_xfer_done(a_xd),
    .o_busy(a_busy), .o_timeout_err(a_terr), .o_xfer_cnt(a_cnt)
  );

  // Requester-0-priority instance
  fx3_xfer_scheduler #(.REQ_NUM(4), .HI_PRIO0(1), .TIMEOUT_W(4)) u_dut_b (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_frame_rst(frame_rst), .i_enable(enable),
    .i_req(req), .i_loader_ready(loader_ready), .i_loader_done(loader_done),
    .o_grant(b_grant), .o_grant_idx(b_idx), .o_xfer_start(b_start), .o_xfer_done(b_xd),
    .o_busy(b_busy), .o_timeout_err(b_terr), .o_xfer_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        done;
    logic [3:0]  rq;
    logic [3:0]  e_grant;
    logic [1:0]  e_idx;
    logic        e_start;
    logic [3:0]  e_xd;
    logic        e_busy;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] o_start(input bit sel);
    return sel ? 32'(b_start) : 32'(a_start);
  endfunction
  function automatic logic [31:0] o_idx(input bit sel);
    return sel ? 32'(b_idx) : 32'(a_idx);
  endfunction
  function automatic logic [31:0] o_grant(input bit sel);
    return sel ? 32'(b_grant) : 32'(a_grant);
  endfunction
  function automatic logic [31:0] o_xd(input bit sel);
    return sel ? 32'(b_xd) : 32'(a_xd);
  endfunction
  function automatic logic [31:0] o_busy(input bit sel);
    return sel ? 32'(b_busy) : 32'(a_busy);
  endfunction
  function automatic logic [31:0] o_cnt(input bit sel);
    return sel ? b_cnt : a_cnt;
  endfunction

  function automatic vec_t mk(input logic en, input logic rdy, input logic done,
                              input logic [3:0] rq, input logic [3:0] eg, input logic [1:0] ei,
                              input logic es, input logic [3:0] ex, input logic eb,
                              input logic [31:0] ec);
    vec_t v;
    v.en = en; v.rdy = rdy; v.done = done; v.rq = rq;
    v.e_grant = eg; v.e_idx = ei; v.e_start = es; v.e_xd = ex; v.e_busy = eb; v.e_cnt = ec;
    return v;
  endfunction

  // Wait (bounded) for xfer_start on the selected instance and check the granted index
  task automatic start_wait(input bit sel, input int exp_idx);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (o_start(sel) == 32'd1) got = 1'b1;
    end
    chk($sformatf("start_seen[%0d]", exp_idx), 32'(got), 32'd1);
    if (got) chk($sformatf("grant_idx[%0d]", exp_idx), o_idx(sel), 32'(exp_idx));
  endtask

  // Called in the first XFER cycle: k more XFER cycles, then loader_done, DONE, IDLE
  task automatic finish(input bit sel, input logic [3:0] exp_oh, input int exp_cnt, input int k);
    repeat (k) tick();
    loader_done = 1'b1;
    tick();
    loader_done = 1'b0;
    chk("done_pulse", o_xd(sel), 32'(exp_oh));
    chk("done_grant", o_grant(sel), 32'(exp_oh));
    tick();
    chk("idle_busy", o_busy(sel), 32'd0);
    chk("idle_grant", o_grant(sel), 32'd0);
    chk("idle_xd", o_xd(sel), 32'd0);
    chk("idle_cnt", o_cnt(sel), 32'(exp_cnt));
  endtask

  task automatic pulse_frame_rst();
    frame_rst = 1'b1;
    tick();
    frame_rst = 1'b0;
  endtask

  // Global bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // single request, ignored loader_done in IDLE/START, ready/enable gating
    tbl[0]  = mk(1, 1, 0, 4'b0100, 4'b0100, 2'd2, 1, 4'b0000, 1, 0);
    tbl[1]  = mk(1, 1, 0, 4'b0100, 4'b0100, 2'd2, 0, 4'b0000, 1, 0);
    tbl[2]  = mk(1, 1, 0, 4'b0100, 4'b0100, 2'd2, 0, 4'b0000, 1, 0);
    tbl[3]  = mk(1, 1, 0, 4'b0100, 4'b0100, 2'd2, 0, 4'b0000, 1, 0);
    tbl[4]  = mk(1, 1, 0, 4'b0100, 4'b0100, 2'd2, 0, 4'b0000, 1, 0);
    tbl[5]  = mk(1, 1, 1, 4'b0100, 4'b0100, 2'd2, 0, 4'b0100, 1, 0);
    tbl[6]  = mk(1, 1, 0, 4'b0000, 4'b0000, 2'd2, 0, 4'b0000, 0, 1);
    tbl[7]  = mk(1, 1, 0, 4'b0000, 4'b0000, 2'd2, 0, 4'b0000, 0, 1);
    tbl[8]  = mk(1, 0, 0, 4'b0010, 4'b0000, 2'd2, 0, 4'b0000, 0, 1);
    tbl[9]  = mk(0, 1, 0, 4'b0010, 4'b0000, 2'd2, 0, 4'b0000, 0, 1);
    tbl[10] = mk(1, 1, 0, 4'b0010, 4'b0010, 2'd1, 1, 4'b0000, 1, 1);
    tbl[11] = mk(1, 1, 1, 4'b0010, 4'b0010, 2'd1, 0, 4'b0000, 1, 1);
    tbl[12] = mk(1, 1, 0, 4'b0010, 4'b0010, 2'd1, 0, 4'b0000, 1, 1);
    tbl[13] = mk(1, 1, 1, 4'b0010, 4'b0010, 2'd1, 0, 4'b0010, 1, 1);
    tbl[14] = mk(1, 1, 0, 4'b0000, 4'b0000, 2'd1, 0, 4'b0000, 0, 2);
    tbl[15] = mk(1, 1, 1, 4'b0000, 4'b0000, 2'd1, 0, 4'b0000, 0, 2);

    // reset state, no clock edge needed
    #3;
    chk("rst_a", {a_grant, a_idx, a_start, a_xd, a_busy, a_terr}, 32'd0);
    chk("rst_a_cnt", a_cnt, 32'd0);
    chk("rst_b", {b_grant, b_idx, b_start, b_xd, b_busy, b_terr}, 32'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    loader_ready = 1'b1;
    tick();
    chk("post_rst_busy", 32'(a_busy), 32'd0);

    for (int i = 0; i < 16; i++) begin
      enable = tbl[i].en;
      loader_ready = tbl[i].rdy;
      loader_done = tbl[i].done;
      req = tbl[i].rq;
      tick();
      chk($sformatf("v%0d grant", i), 32'(a_grant), 32'(tbl[i].e_grant));
      chk($sformatf("v%0d idx", i), 32'(a_idx), 32'(tbl[i].e_idx));
      chk($sformatf("v%0d start", i), 32'(a_start), 32'(tbl[i].e_start));
      chk($sformatf("v%0d xd", i), 32'(a_xd), 32'(tbl[i].e_xd));
      chk($sformatf("v%0d busy", i), 32'(a_busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d cnt", i), a_cnt, tbl[i].e_cnt);
    end
    loader_done = 1'b0;
    enable = 1'b1;
    loader_ready = 1'b1;
    req = 4'b0000;

    // round-robin with all requesters held
    pulse_frame_rst();
    chk("rr_clr_cnt", a_cnt, 32'd0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (k % 4);
      start_wait(1'b0, k % 4);
      tick();
      finish(1'b0, oh, k + 1, 2);
    end
    req = 4'b0000;

    // requester 0 priority: 1, then 0, then 3, then 1
    pulse_frame_rst();
    req = 4'b1010;
    start_wait(1'b1, 1);
    tick();
    req = 4'b1011;
    finish(1'b1, 4'b0010, 1, 1);
    req = 4'b1001;
    start_wait(1'b1, 0);
    tick();
    finish(1'b1, 4'b0001, 2, 1);
    req = 4'b1000;
    start_wait(1'b1, 3);
    tick();
    finish(1'b1, 4'b1000, 3, 1);
    req = 4'b1010;
    start_wait(1'b1, 1);
    tick();
    finish(1'b1, 4'b0010, 4, 1);
    req = 4'b0000;

    // timeout: DONE 16 cycles after entering XFER
    pulse_frame_rst();
    req = 4'b0001;
    start_wait(1'b0, 0);
    tick();
    for (int k = 1; k < 16; k++) begin
      tick();
      chk($sformatf("to_wait%0d", k), {a_xd, a_terr, a_busy}, {4'b0000, 1'b0, 1'b1});
    end
    tick();
    chk("to_done_xd", 32'(a_xd), 32'b0001);
    chk("to_err", 32'(a_terr), 32'd1);
    tick();
    chk("to_cnt", a_cnt, 32'd0);
    chk("to_err_sticky", 32'(a_terr), 32'd1);
    start_wait(1'b0, 0);
    tick();
    finish(1'b0, 4'b0001, 1, 1);
    chk("to_err_kept", 32'(a_terr), 32'd1);

    // frame_rst abort in XFER, then scan restarts at 0
    req = 4'b0100;
    start_wait(1'b0, 2);
    tick();
    frame_rst = 1'b1;
    tick();
    frame_rst = 1'b0;
    req = 4'b0011;
    chk("abort_state", {a_grant, a_start, a_xd, a_busy, a_terr}, 32'd0);
    chk("abort_cnt", a_cnt, 32'd0);
    start_wait(1'b0, 0);

    // asynchronous reset mid-transfer
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a", {a_grant, a_idx, a_start, a_xd, a_busy, a_terr}, 32'd0);
    chk("arst_b", {b_grant, b_idx, b_start, b_xd, b_busy, b_terr}, 32'd0);
    chk("arst_cnt", a_cnt, 32'd0);
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_idle", 32'(a_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
